keyin_ctrl: RTL

KEYIN_CTRL -- requirements
Module: keyin_ctrl

---
 rtl/keyin_pkg.sv | 15 +
 rtl/key_fifo.sv | 58 +++++
 rtl/keyin_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/keyin_pkg.sv
// Shared types and widths for the key-input controller: FSM state encoding
// and the key-code / occupancy widths used by the controller and its FIFO.
package keyin_pkg;

    localparam int CODE_W  = 4;
    localparam int COUNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_HELD       = 2'd2,
        ST_RELEASE_DB = 2'd3
    } keyin_state_e;

endpackage

// File: rtl/key_fifo.sv
// Small key-code FIFO with registered storage and occupancy count.
// A push while full is accepted only when a pop happens in the same cycle.
module key_fifo
    import keyin_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic [CODE_W-1:0]  push_data,
    input  logic               pop,
    output logic [CODE_W-1:0]  pop_data,
    output logic               full,
    output logic               empty,
    output logic [COUNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CODE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty    = (count == '0);
    assign full     = (count == COUNT_W'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // DEPTH is a power of two, so plain pointer increment wraps modulo DEPTH.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + COUNT_W'(1);
                2'b01:   count <= count - COUNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/keyin_ctrl.sv
// Keypad front end: synchronizes the encoder outputs, debounces press and
// release, and queues one key code per press into a small FIFO.
module keyin_ctrl
    import keyin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               key_in,
    input  logic [CODE_W-1:0]  key_val,
    output logic               out_valid,
    output logic [CODE_W-1:0]  out_code,
    input  logic               out_ready,
    output logic [COUNT_W-1:0] count,
    output logic               overflow,
    input  logic               clr_ovf,
    output keyin_state_e       dbg_state
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CODE_W:0]   sync1;
    logic [CODE_W:0]   sync2;
    logic              key_s;
    logic [CODE_W-1:0] val_s;

    keyin_state_e      state;
    keyin_state_e      state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [CODE_W-1:0] cand;
    logic              cnt_last;
    logic              same_key;

    logic              push;
    logic              cand_load;
    logic              cnt_clr;
    logic              cnt_inc;

    logic              fifo_full;
    logic              fifo_empty;
    logic              drop;

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {key_in, key_val};
            sync2 <= sync1;
        end
    end

    assign key_s     = sync2[CODE_W];
    assign val_s     = sync2[CODE_W-1:0];
    assign cnt_last  = (cnt == CNT_LAST);
    assign same_key  = key_s && (val_s == cand);
    assign dbg_state = state;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:       if (key_s) state_nx = ST_PRESS_DB;
            ST_PRESS_DB: begin
                if (!same_key)     state_nx = ST_IDLE;
                else if (cnt_last) state_nx = ST_HELD;
            end
            ST_HELD:       if (!key_s) state_nx = ST_RELEASE_DB;
            ST_RELEASE_DB: begin
                if (key_s)         state_nx = ST_HELD;
                else if (cnt_last) state_nx = ST_IDLE;
            end
            default:       state_nx = ST_IDLE;
        endcase
    end

    // Value changes while HELD are ignored, so exactly one code per press.
    always_comb begin
        push      = 1'b0;
        cand_load = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            ST_IDLE: begin
                cand_load = key_s;
                cnt_clr   = key_s;
            end
            ST_PRESS_DB: begin
                push    = same_key && cnt_last;
                cnt_inc = same_key && !cnt_last;
            end
            ST_HELD:       cnt_clr = !key_s;
            ST_RELEASE_DB: cnt_inc = !key_s && !cnt_last;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt  <= '0;
            cand <= '0;
        end else begin
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (cand_load) begin
                cand <= val_s;
            end
        end
    end

    // Handshake: out_valid/out_code come straight from FIFO registers; a
    // transfer happens on a rising edge where out_valid and out_ready are both 1.
    key_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .push_data(cand),
        .pop      (out_ready),
        .pop_data (out_code),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (count)
    );

    assign out_valid = !fifo_empty;
    assign drop      = push && fifo_full && !out_ready;

    always_ff @(posedge clock) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule
